// File: rtl/axi4_stream_upsizer_pkg.sv
// Shared widths and word type for the AXI4-Stream upsizer.
// Defaults describe the 8-bit to 32-bit configuration.
`timescale 1ns/1ps
package axi4_stream_upsizer_pkg;

    localparam int UP_DW     = 8;
    localparam int UP_RATIO  = 4;
    localparam int UP_OUT_W  = UP_DW * UP_RATIO;
    localparam int UP_KEEP_W = UP_OUT_W / 8;
    localparam int UP_CNT_W  = $clog2(UP_RATIO);

    typedef struct packed {
        logic [UP_OUT_W-1:0]  data;
        logic [UP_KEEP_W-1:0] keep;
        logic                 last;
    } up_word_t;

    function automatic int keep_width(input int dw, input int ratio);
        return dw * ratio / 8;
    endfunction

endpackage

// File: rtl/axi4_stream_reg_slice.sv
// One-entry valid/ready register; reloads in the same cycle it drains.
`timescale 1ns/1ps
module axi4_stream_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4_stream_upsizer.sv
// Packs RATIO narrow AXI4-Stream beats into one wide word;
// TLAST closes a word early with TKEEP marking the filled lanes.
`timescale 1ns/1ps
module axi4_stream_upsizer
    import axi4_stream_upsizer_pkg::*;
#(
    parameter int DW    = UP_DW,
    parameter int RATIO = UP_RATIO
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        s_axis_TVALID,
    output logic                        s_axis_TREADY,
    input  logic [DW-1:0]               s_axis_TDATA,
    input  logic                        s_axis_TLAST,
    output logic                        m_axis_TVALID,
    input  logic                        m_axis_TREADY,
    output logic [DW*RATIO-1:0]         m_axis_TDATA,
    output logic [keep_width(DW,RATIO)-1:0] m_axis_TKEEP,
    output logic                        m_axis_TLAST
);

    localparam int OW = DW * RATIO;
    localparam int KW = keep_width(DW, RATIO);
    localparam int LK = DW / 8;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int SW = OW + KW + 1;

    logic [CW-1:0] cnt;
    logic [OW-1:0] acc_data;
    logic [KW-1:0] acc_keep;
    logic [OW-1:0] nxt_data;
    logic [KW-1:0] nxt_keep;
    logic          s_hs;
    logic          done;
    logic          slice_ready;
    logic [SW-1:0] slice_out;

    assign s_axis_TREADY = ARESETn & slice_ready;
    assign s_hs = s_axis_TVALID & s_axis_TREADY;
    assign done = s_hs & ((cnt == CW'(RATIO - 1)) | s_axis_TLAST);

    // Lanes above cnt are always zero in the accumulator, so a
    // partial word leaves its unused lanes at TDATA=0, TKEEP=0.
    always_comb begin
        nxt_data = acc_data;
        nxt_keep = acc_keep;
        nxt_data[cnt*DW +: DW] = s_axis_TDATA;
        nxt_keep[cnt*LK +: LK] = '1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (done) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (s_hs) begin
            cnt      <= cnt + 1'b1;
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
        end
    end

    axi4_stream_reg_slice #(
        .W(SW)
    ) u_out (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .in_valid  (done),
        .in_ready  (slice_ready),
        .in_data   ({nxt_data, nxt_keep, s_axis_TLAST}),
        .out_valid (m_axis_TVALID),
        .out_ready (m_axis_TREADY),
        .out_data  (slice_out)
    );

    assign {m_axis_TDATA, m_axis_TKEEP, m_axis_TLAST} = slice_out;

endmodule
